inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 99 +++++++++
 tb/tb_inst_encoder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Single-stage instruction encoder: packs R/I/J request fields into a 32-bit word,
// rejects illegal format/opcode combinations and keeps per-format issue counters.
module inst_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err,
    output logic [15:0] r_count,
    output logic [15:0] i_count,
    output logic [15:0] j_count,
    output logic [15:0] err_count
);

    localparam logic [1:0] FMT_R = 2'd0;
    localparam logic [1:0] FMT_I = 2'd1;
    localparam logic [1:0] FMT_J = 2'd2;

    logic        accept;
    logic        legal;
    logic [31:0] word;
    logic [31:0] inst_p1;
    logic        vld_p1;
    logic        err_p1;

    // Opcodes 0, 2 and 3 belong to R-type and jumps, so they are not valid I-type opcodes.
    always_comb begin
        legal = 1'b0;
        word  = 32'd0;
        case (fmt)
            FMT_R: begin
                legal = 1'b1;
                word  = {6'd0, rs, rt, rd, shamt, funct};
            end
            FMT_I: begin
                legal = (opcode != 6'd0) && (opcode != 6'd2) && (opcode != 6'd3);
                word  = {opcode, rs, rt, imm};
            end
            FMT_J: begin
                legal = (opcode == 6'd2) || (opcode == 6'd3);
                word  = {opcode, target};
            end
            default: begin
                legal = 1'b0;
                word  = 32'd0;
            end
        endcase
    end

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // Stage p1: output register, error pulse and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_p1   <= 32'd0;
            vld_p1    <= 1'b0;
            err_p1    <= 1'b0;
            r_count   <= 16'd0;
            i_count   <= 16'd0;
            j_count   <= 16'd0;
            err_count <= 16'd0;
        end else begin
            err_p1 <= accept && !legal;
            if (accept) begin
                vld_p1 <= legal;
                if (legal) begin
                    inst_p1 <= word;
                    case (fmt)
                        FMT_R:   r_count <= r_count + 16'd1;
                        FMT_I:   i_count <= i_count + 16'd1;
                        default: j_count <= j_count + 16'd1;
                    endcase
                end else begin
                    err_count <= err_count + 16'd1;
                end
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign inst      = inst_p1;
    assign out_valid = vld_p1;
    assign err       = err_p1;

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized scoreboard bench for inst_encoder: a driver feeds requests and a
// behavioural model, a separate monitor pops expectations as words/errors appear.
module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] inst;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [15:0] r_count, i_count, j_count, err_count;

    inst_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready), .err(err),
        .r_count(r_count), .i_count(i_count), .j_count(j_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f, op, rs, rt, rd, sh, fn, imm, tgt;
    } req_t;

    typedef struct {
        bit          legal;
        logic [31:0] word;
        logic [15:0] rc, ic, jc, ec;
    } item_t;

    item_t       exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] m_r = 0, m_i = 0, m_j = 0, m_e = 0;
    bit          prev_acc = 0;
    bit          prev_legal = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_legal(input req_t r);
        if (r.f == 0) return 1;
        if (r.f == 1) return !(r.op == 0 || r.op == 2 || r.op == 3);
        if (r.f == 2) return (r.op == 2 || r.op == 3);
        return 0;
    endfunction

    function automatic logic [31:0] model_word(input req_t r);
        longint w;
        if (r.f == 0)
            w = longint'(r.rs) * 2097152 + longint'(r.rt) * 65536 + longint'(r.rd) * 2048
                + longint'(r.sh) * 64 + longint'(r.fn);
        else if (r.f == 1)
            w = longint'(r.op) * 67108864 + longint'(r.rs) * 2097152 + longint'(r.rt) * 65536
                + longint'(r.imm);
        else
            w = longint'(r.op) * 67108864 + longint'(r.tgt);
        return w[31:0];
    endfunction

    function automatic req_t mk(input int f, input int op, input int a, input int b,
                                input int c, input int d, input int e, input int im,
                                input int tg);
        req_t r;
        r.f = f; r.op = op; r.rs = a; r.rt = b; r.rd = c; r.sh = d; r.fn = e;
        r.imm = im; r.tgt = tg;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   pick;
        r.f  = int'($urandom_range(0, 3));
        pick = int'($urandom_range(0, 4));
        r.op = (pick == 0) ? 0 : (pick == 1) ? 2 : (pick == 2) ? 3 : int'($urandom_range(0, 63));
        r.rs = int'($urandom_range(0, 31));
        r.rt = int'($urandom_range(0, 31));
        r.rd = int'($urandom_range(0, 31));
        r.sh = int'($urandom_range(0, 31));
        r.fn = int'($urandom_range(0, 63));
        r.imm = int'($urandom_range(0, 65535));
        r.tgt = int'($urandom_range(0, 26'h3FFFFFF));
        return r;
    endfunction

    // One clock of stimulus; when accepted, the model result is queued for the monitor.
    task automatic drive(input bit v, input req_t r, input bit ordy, input bit use_const,
                         input logic [31:0] cexp, output bit acc);
        item_t it;
        @(negedge clk);
        in_valid  = v;
        fmt       = r.f[1:0];
        opcode    = r.op[5:0];
        rs        = r.rs[4:0];
        rt        = r.rt[4:0];
        rd        = r.rd[4:0];
        shamt     = r.sh[4:0];
        funct     = r.fn[5:0];
        imm       = r.imm[15:0];
        target    = r.tgt[25:0];
        out_ready = ordy;
        #1;
        if (prev_acc) begin
            chk("vld_after_accept", out_valid, prev_legal);
            chk("err_after_accept", err, !prev_legal);
        end
        acc = v && in_ready;
        prev_acc = acc;
        if (acc) begin
            it.legal = model_legal(r);
            if (it.legal) begin
                if (r.f == 0) m_r = m_r + 1;
                else if (r.f == 1) m_i = m_i + 1;
                else m_j = m_j + 1;
            end else begin
                m_e = m_e + 1;
            end
            it.word = use_const ? cexp : model_word(r);
            it.rc = m_r; it.ic = m_i; it.jc = m_j; it.ec = m_e;
            exp_q.push_back(it);
            prev_legal = it.legal;
        end
    endtask

    task automatic idle(input bit ordy);
        bit a;
        drive(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), ordy, 0, 32'd0, a);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_inst"}, inst, 0);
        chk({tag, "_r_count"}, r_count, 0);
        chk({tag, "_i_count"}, i_count, 0);
        chk({tag, "_j_count"}, j_count, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    // Monitor: pops on output handshake or error pulse, checks held words under backpressure.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (reset !== 1'b0) continue;
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (err) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_err: got err=1 expected no pending request");
                end else begin
                    it = exp_q.pop_front();
                    chk("err_is_reject", it.legal, 0);
                    chk("err_count", err_count, it.ec);
                    chk("err_j_count", j_count, it.jc);
                    chk("err_out_valid", out_valid, 0);
                end
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", inst);
                end else begin
                    it = exp_q.pop_front();
                    chk("word_is_legal", it.legal, 1);
                    chk("inst", inst, it.word);
                    chk("r_count", r_count, it.rc);
                    chk("i_count", i_count, it.ic);
                    chk("j_count", j_count, it.jc);
                    chk("err_count_word", err_count, it.ec);
                end
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL held_word: got 0x%0h expected none", inst);
                end else begin
                    chk("held_inst", inst, exp_q[0].word);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        req_t r;
        reset = 1; in_valid = 0; out_ready = 0;
        fmt = 0; opcode = 0; rs = 0; rt = 0; rd = 0; shamt = 0; funct = 0; imm = 0; target = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        // A request presented during reset must not be taken.
        in_valid = 1; fmt = 0; out_ready = 1;
        @(negedge clk);
        check_all_zero("reset_hold");
        in_valid = 0;
        @(posedge clk);
        #2 reset = 0;

        drive(1, mk(0, 63, 10, 11, 9, 0, 32, 0, 0), 1, 1, 32'h014B4820, acc);
        chk("first_acc", acc, 1);
        drive(1, mk(1, 8, 0, 8, 0, 0, 0, 5, 0), 1, 1, 32'h20080005, acc);
        drive(1, mk(2, 2, 0, 0, 0, 0, 0, 0, 26'h0100000), 1, 1, 32'h08100000, acc);
        drive(1, mk(2, 4, 0, 0, 0, 0, 0, 0, 5), 1, 0, 32'd0, acc);
        idle(1);
        idle(1);

        // Backpressure, then back-to-back replacement on the first ready cycle.
        drive(1, mk(1, 35, 3, 4, 0, 0, 0, 16'hBEEF, 0), 0, 0, 32'd0, acc);
        for (int k = 0; k < 5; k++) begin
            drive(1, mk(0, 0, 1, 2, 3, 4, 5, 0, 0), 0, 0, 32'd0, acc);
            chk("bp_no_accept", acc, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        drive(1, mk(0, 0, 1, 2, 3, 4, 5, 0, 0), 1, 0, 32'd0, acc);
        chk("b2b_accept", acc, 1);
        // Illegal request replacing a presented word drops out_valid.
        drive(1, mk(2, 3, 0, 0, 0, 0, 0, 0, 26'h2ABCDEF), 0, 0, 32'd0, acc);
        drive(1, mk(3, 8, 0, 0, 0, 0, 0, 0, 0), 1, 0, 32'd0, acc);
        chk("reject_replace_accept", acc, 1);
        idle(1);
        idle(1);

        for (int k = 0; k < 1500; k++) begin
            r = rand_req();
            drive(($urandom_range(0, 3) != 0), r, ($urandom_range(0, 2) != 0), 0, 32'd0, acc);
        end
        idle(1);
        idle(1);

        // Asynchronous reset with a word pending.
        drive(1, mk(0, 0, 7, 7, 7, 7, 7, 0, 0), 0, 0, 32'd0, acc);
        @(negedge clk);
        #3 reset = 1;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        m_r = 0; m_i = 0; m_j = 0; m_e = 0;
        prev_acc = 0;
        @(negedge clk);
        check_all_zero("async_reset_hold");
        @(posedge clk);
        #2 reset = 0;

        // Counter wrap: 65536 legal I-type requests in total.
        drive(1, mk(1, 8, 1, 1, 0, 0, 0, 1, 0), 1, 0, 32'd0, acc);
        chk("first_acc_after_reset", acc, 1);
        for (int k = 1; k < 65535; k++) begin
            r = mk(1, int'($urandom_range(8, 63)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 31)), 0, 0, 0, int'($urandom_range(0, 65535)), 0);
            drive(1, r, 1, 0, 32'd0, acc);
        end
        idle(1);
        chk("i_count_ffff", i_count, 16'hFFFF);
        drive(1, mk(1, 9, 2, 2, 0, 0, 0, 2, 0), 1, 0, 32'd0, acc);
        idle(1);
        chk("i_count_wrap", i_count, 16'h0000);
        idle(1);
        idle(1);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
